// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser
//   Payout side of the coin interface. Takes a change request (in 1-unit
//   coin values), pays it out greedily (2-unit coins first, falling back to
//   1-unit coins) by pulsing one hopper eject line per coin and waiting for
//   the hopper ack. Tracks on-board stock for both coin types. A missing
//   ack parks the block in FAULT until 'clear'.
//
//   Optional feature: define COIN_CHANGE_STATS_EN to build the lifetime
//   total_paid counter (16-bit, wraps, cleared only by reset). Without it
//   total_paid is tied to zero.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_amount  change request; accepted when req_ready (IDLE)
//   req_ready             high only in IDLE
//   eject1/eject2         one-cycle eject pulse for a 1-/2-unit coin
//   hopper_ack            hopper confirms the last ejected coin
//   refill                reload both stock counters to INIT values
//   clear                 leave FAULT
//   done                  one-cycle pulse when a payout finishes
//   short/paid            payout incomplete flag / amount paid; held to next accept
//   fault                 high in FAULT
//   stock1/stock2         current coin stock
//   total_paid            lifetime units paid (COIN_CHANGE_STATS_EN)
module coin_change_dispenser #(
  parameter int AMT_W       = 4,
  parameter int CNT_W       = 4,
  parameter int INIT_C1     = 8,
  parameter int INIT_C2     = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             eject1,
  output logic             eject2,
  input  logic             hopper_ack,
  input  logic             refill,
  input  logic             clear,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] paid,
  output logic             fault,
  output logic [CNT_W-1:0] stock1,
  output logic [CNT_W-1:0] stock2,
  output logic [15:0]      total_paid
);

  localparam logic [AMT_W-1:0] L_AMT_ONE = AMT_W'(1);
  localparam logic [AMT_W-1:0] L_AMT_TWO = AMT_W'(2);
  localparam logic [CNT_W-1:0] L_STK_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_INIT_C1 = CNT_W'(INIT_C1);
  localparam logic [CNT_W-1:0] L_INIT_C2 = CNT_W'(INIT_C2);
  localparam logic [3:0]       L_TIMEOUT = 4'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_EJECT,
    S_WAIT_ACK,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [AMT_W-1:0] r_remaining;
  logic [AMT_W-1:0] r_paid;
  logic             r_short;
  logic             r_coin2;     // coin in flight is a 2-unit coin
  logic [3:0]       r_ack_cnt;
  logic [CNT_W-1:0] r_stock1;
  logic [CNT_W-1:0] r_stock2;

  logic             w_accept;
  logic             w_pick2;
  logic             w_pick1;
  logic             w_finish;
  logic             w_ack_ok;
  logic             w_dec1;
  logic             w_dec2;
  logic [AMT_W-1:0] w_coin;

  // NOTE: every output and decision signal gets a default before the case,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    eject1       = 1'b0;
    eject2       = 1'b0;
    done         = 1'b0;
    fault        = 1'b0;
    w_accept     = 1'b0;
    w_pick2      = 1'b0;
    w_pick1      = 1'b0;
    w_finish     = 1'b0;
    w_ack_ok     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_SEL;
        end
      end
      S_SEL: begin
        // Greedy choice: a coin is only picked if it fits in what is left,
        // so remaining can never underflow.
        if (r_remaining >= L_AMT_TWO && r_stock2 != '0) begin
          w_pick2      = 1'b1;
          w_next_state = S_EJECT;
        end else if (r_remaining != '0 && r_stock1 != '0) begin
          w_pick1      = 1'b1;
          w_next_state = S_EJECT;
        end else begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_EJECT: begin
        eject2       = r_coin2;
        eject1       = ~r_coin2;
        w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An ack on the last allowed cycle still counts.
        if (hopper_ack) begin
          w_ack_ok     = 1'b1;
          w_next_state = S_SEL;
        end else if (r_ack_cnt == L_TIMEOUT) begin
          w_next_state = S_FAULT;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
        if (clear) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  assign w_coin = r_coin2 ? L_AMT_TWO : L_AMT_ONE;
  assign w_dec1 = w_ack_ok & ~r_coin2;
  assign w_dec2 = w_ack_ok & r_coin2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remaining <= '0;
      r_paid      <= '0;
      r_short     <= 1'b0;
      r_coin2     <= 1'b0;
      r_ack_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_remaining <= req_amount;
        r_paid      <= '0;
        r_short     <= 1'b0;
      end else if (w_ack_ok) begin
        r_remaining <= r_remaining - w_coin;
        r_paid      <= r_paid + w_coin;
      end

      if (w_pick2)      r_coin2 <= 1'b1;
      else if (w_pick1) r_coin2 <= 1'b0;

      // Leaving SEL with nothing payable: short if anything is still owed.
      if (w_finish) r_short <= (r_remaining != '0);

      // Saturate at the limit; WAIT_ACK leaves for FAULT on that cycle.
      if (r_state == S_EJECT)
        r_ack_cnt <= '0;
      else if (r_state == S_WAIT_ACK && !hopper_ack && r_ack_cnt != L_TIMEOUT)
        r_ack_cnt <= r_ack_cnt + 4'd1;
    end
  end

  // Refill wins over the old count, but an ack on the same edge still
  // consumes one coin from the freshly loaded stock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stock1 <= L_INIT_C1;
      r_stock2 <= L_INIT_C2;
    end else begin
      if (refill)      r_stock1 <= w_dec1 ? L_INIT_C1 - L_STK_ONE : L_INIT_C1;
      else if (w_dec1) r_stock1 <= r_stock1 - L_STK_ONE;

      if (refill)      r_stock2 <= w_dec2 ? L_INIT_C2 - L_STK_ONE : L_INIT_C2;
      else if (w_dec2) r_stock2 <= r_stock2 - L_STK_ONE;
    end
  end

`ifdef COIN_CHANGE_STATS_EN
  logic [15:0] r_total;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_total <= '0;
    else if (w_ack_ok) r_total <= r_total + 16'(w_coin);
  end

  assign total_paid = r_total;
`else
  assign total_paid = 16'd0;
`endif

  assign short  = r_short;
  assign paid   = r_paid;
  assign stock1 = r_stock1;
  assign stock2 = r_stock2;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Testbench for coin_change_dispenser: a transaction-level payout model
// (greedy coin list from plain arithmetic on stock counts) produces the
// expected outputs for every cycle; a negedge process compares them.
module tb_coin_change_dispenser;

  localparam int AMT_W       = 4;
  localparam int CNT_W       = 4;
  localparam int INIT_C1     = 8;
  localparam int INIT_C2     = 8;
  localparam int ACK_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             hopper_ack = 1'b0;
  logic             refill = 1'b0;
  logic             clear = 1'b0;
  logic             req_ready;
  logic             eject1;
  logic             eject2;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] paid;
  logic             fault;
  logic [CNT_W-1:0] stock1;
  logic [CNT_W-1:0] stock2;
  logic [15:0]      total_paid;

  coin_change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_C1(INIT_C1), .INIT_C2(INIT_C2),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .eject1(eject1), .eject2(eject2),
    .hopper_ack(hopper_ack), .refill(refill), .clear(clear), .done(done),
    .short(short), .paid(paid), .fault(fault), .stock1(stock1),
    .stock2(stock2), .total_paid(total_paid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [CNT_W-1:0] m_stock1;
  logic [CNT_W-1:0] m_stock2;
  logic [AMT_W-1:0] m_paid;
  logic             m_short;
  logic [15:0]      m_total;

  // Expected outputs for the current cycle
  logic             exp_on = 1'b0;
  logic             exp_ready, exp_ej1, exp_ej2, exp_done, exp_fault, exp_short;
  logic [AMT_W-1:0] exp_paid;
  logic [CNT_W-1:0] exp_stock1, exp_stock2;
  logic [15:0]      exp_total;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      check("req_ready",  16'(req_ready),  16'(exp_ready));
      check("eject1",     16'(eject1),     16'(exp_ej1));
      check("eject2",     16'(eject2),     16'(exp_ej2));
      check("done",       16'(done),       16'(exp_done));
      check("fault",      16'(fault),      16'(exp_fault));
      check("short",      16'(short),      16'(exp_short));
      check("paid",       16'(paid),       16'(exp_paid));
      check("stock1",     16'(stock1),     16'(exp_stock1));
      check("stock2",     16'(stock2),     16'(exp_stock2));
      check("total_paid", total_paid,      exp_total);
    end
  end

  function automatic logic flip(input logic en, input int one_in);
    return en && ($urandom_range(0, one_in - 1) == 0);
  endfunction

  function automatic int pick_delay();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(14, 20));
    return int'($urandom_range(0, 3));
  endfunction

  // Drive one cycle of inputs, publish the expected outputs for it, then
  // advance past the edge and apply any refill to the model.
  task automatic run_cycle(input logic rv, input logic [AMT_W-1:0] ra,
                           input logic ack, input logic rf, input logic clr,
                           input logic e_ready, input logic e_ej1,
                           input logic e_ej2, input logic e_done,
                           input logic e_fault);
    req_valid  = rv;
    req_amount = ra;
    hopper_ack = ack;
    refill     = rf;
    clear      = clr;
    exp_ready  = e_ready;
    exp_ej1    = e_ej1;
    exp_ej2    = e_ej2;
    exp_done   = e_done;
    exp_fault  = e_fault;
    exp_short  = m_short;
    exp_paid   = m_paid;
    exp_stock1 = m_stock1;
    exp_stock2 = m_stock2;
    exp_total  = m_total;
    @(posedge clk); #1;
    if (rf) begin
      m_stock1 = CNT_W'(INIT_C1);
      m_stock2 = CNT_W'(INIT_C2);
    end
  endtask

  // One request: accept, then a greedy coin at a time from the model stock.
  // fixed_delay < 0 picks a random ack delay per coin; a delay beyond the
  // timeout drives the fault/clear path instead.
  task automatic pay(input logic [AMT_W-1:0] amt, input int fixed_delay,
                     input logic noise, input logic refill_on_ack);
    int rem;
    int coin;
    int d;
    int n;
    rem = int'(amt);
    run_cycle(1'b1, amt, flip(noise, 4), flip(noise, 20), flip(noise, 4),
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    m_paid  = '0;
    m_short = 1'b0;
    forever begin
      if (rem >= 2 && m_stock2 != 0)      coin = 2;
      else if (rem >= 1 && m_stock1 != 0) coin = 1;
      else                                coin = 0;
      run_cycle(flip(noise, 4), AMT_W'($urandom), flip(noise, 4), flip(noise, 20),
                flip(noise, 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (coin == 0) break;
      run_cycle(flip(noise, 4), AMT_W'($urandom), flip(noise, 4), flip(noise, 20),
                flip(noise, 4), 1'b0, coin == 1, coin == 2, 1'b0, 1'b0);
      d = (fixed_delay >= 0) ? fixed_delay : pick_delay();
      if (d > ACK_TIMEOUT) begin
        repeat (ACK_TIMEOUT + 1)
          run_cycle(flip(noise, 4), AMT_W'($urandom), 1'b0, flip(noise, 20),
                    flip(noise, 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n = int'($urandom_range(1, 3));
        for (int k = 0; k < n; k++)
          run_cycle(flip(noise, 4), AMT_W'($urandom), flip(noise, 4), flip(noise, 20),
                    k == n - 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
      repeat (d)
        run_cycle(flip(noise, 4), AMT_W'($urandom), 1'b0, flip(noise, 20),
                  flip(noise, 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cycle(flip(noise, 4), AMT_W'($urandom), 1'b1,
                refill_on_ack | flip(noise, 20), flip(noise, 4),
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rem    = rem - coin;
      m_paid = m_paid + AMT_W'(coin);
`ifdef COIN_CHANGE_STATS_EN
      m_total = m_total + 16'(coin);
`endif
      if (coin == 2) m_stock2 = m_stock2 - CNT_W'(1);
      else           m_stock1 = m_stock1 - CNT_W'(1);
    end
    m_short = (rem != 0);
    run_cycle(flip(noise, 4), AMT_W'($urandom), flip(noise, 4), flip(noise, 20),
              flip(noise, 4), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_amount = '0;
    hopper_ack = 1'b0;
    refill     = 1'b0;
    clear      = 1'b0;
    m_stock1   = CNT_W'(INIT_C1);
    m_stock2   = CNT_W'(INIT_C2);
    m_paid     = '0;
    m_short    = 1'b0;
    m_total    = '0;
    exp_ready  = 1'b1;
    exp_ej1    = 1'b0;
    exp_ej2    = 1'b0;
    exp_done   = 1'b0;
    exp_fault  = 1'b0;
    exp_short  = 1'b0;
    exp_paid   = '0;
    exp_stock1 = m_stock1;
    exp_stock2 = m_stock2;
    exp_total  = '0;
    exp_on     = 1'b1;
    @(posedge clk); #1;
    check("rst_ready",  16'(req_ready), 16'd1);
    check("rst_eject2", 16'(eject2),    16'd0);
    check("rst_fault",  16'(fault),     16'd0);
    check("rst_paid",   16'(paid),      16'd0);
    check("rst_stock1", 16'(stock1),    16'd8);
    check("rst_stock2", 16'(stock2),    16'd8);
    check("rst_total",  total_paid,     16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 5 -> 2,2,1 with prompt acks
    pay(4'd5, 0, 1'b0, 1'b0);
    check("t1_paid",   16'(paid),   16'd5);
    check("t1_short",  16'(short),  16'd0);
    check("t1_stock2", 16'(stock2), 16'd6);
    check("t1_stock1", 16'(stock1), 16'd7);

    // zero amount: done two cycles after accept, no coins
    pay(4'd0, 0, 1'b0, 1'b0);
    check("t2_paid",  16'(paid),  16'd0);
    check("t2_short", 16'(short), 16'd0);

    // drain 2-unit stock, then pay 3 with only two 1-unit coins left
    pay(4'd15, 1, 1'b0, 1'b0);
    check("t3a_paid",   16'(paid),   16'd15);
    check("t3a_stock2", 16'(stock2), 16'd0);
    pay(4'd2, 0, 1'b0, 1'b0);
    check("t3b_stock1", 16'(stock1), 16'd2);
    pay(4'd3, 0, 1'b0, 1'b0);
    check("t3_paid",   16'(paid),   16'd2);
    check("t3_short",  16'(short),  16'd1);
    check("t3_stock1", 16'(stock1), 16'd0);

    // refill coinciding with a 2-unit ack
    run_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pay(4'd4, 0, 1'b0, 1'b0);
    check("t5a_stock2", 16'(stock2), 16'd6);
    pay(4'd2, 0, 1'b0, 1'b1);
    check("t5_stock2", 16'(stock2), 16'd7);
    check("t5_stock1", 16'(stock1), 16'd8);

    // ack withheld -> fault, clear -> IDLE with paid=0
    pay(4'd2, 99, 1'b0, 1'b0);
    check("t4_ready", 16'(req_ready), 16'd1);
    check("t4_fault", 16'(fault),     16'd0);
    check("t4_paid",  16'(paid),      16'd0);

    // randomized traffic
    for (int t = 0; t < 40; t++)
      pay(AMT_W'($urandom_range(0, 15)), -1, 1'b1, 1'b0);

    // reset in the middle of WAIT_ACK
    run_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    m_paid  = '0;
    m_short = 1'b0;
    run_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // two payouts of 5 after reset
    pay(4'd5, 0, 1'b0, 1'b0);
    pay(4'd5, 1, 1'b0, 1'b0);
    check("t6_paid",   16'(paid),   16'd5);
    check("t6_stock2", 16'(stock2), 16'd4);
    check("t6_stock1", 16'(stock1), 16'd6);
`ifdef COIN_CHANGE_STATS_EN
    check("t6_total", total_paid, 16'd10);
`else
    check("t6_total", total_paid, 16'd0);
`endif

    exp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
